// File: rtl/bip_control_if.sv
// Program-ROM and datapath/data-RAM bus driven by the bip_control sequencer.
// The master side is the controller; the slave side is the ROM plus datapath.
interface bip_control_if #(
    parameter int PC_WIDTH    = 11,
    parameter int INSTR_WIDTH = 16
);
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    operand;
    logic [1:0]             sel_a;
    logic                   sel_b;
    logic                   op;
    logic                   wr_acc;
    logic                   rd_ram;
    logic                   wr_ram;

    modport master (
        output pc, operand, sel_a, sel_b, op, wr_acc, rd_ram, wr_ram,
        input  instr
    );

    modport slave (
        input  pc, operand, sel_a, sel_b, op, wr_acc, rd_ram, wr_ram,
        output instr
    );
endinterface

// File: rtl/bip_control.sv
// Three-cycle FETCH/DECODE/EXEC sequencer for the accumulator datapath.
// Optional executed-cycle counter enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control #(
    parameter int PC_WIDTH     = 11,
    parameter int OPCODE_WIDTH = 5,
    parameter int INSTR_WIDTH  = 16,
    parameter int CYCLE_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    bip_control_if.master          bus,
    output logic                   halted,
    output logic [CYCLE_WIDTH-1:0] cycles
);

    if (INSTR_WIDTH != OPCODE_WIDTH + PC_WIDTH) begin : g_width_check
        $error("bip_control: INSTR_WIDTH must equal OPCODE_WIDTH + PC_WIDTH");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       rd_ram;
        logic       wr_ram;
    } ctrl_t;

    localparam logic [OPCODE_WIDTH-1:0] OPC_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI = OPCODE_WIDTH'(7);

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    // Opcodes 01000-11111 fall through to the all-zero NOP word.
    function automatic ctrl_t decode(input logic [OPCODE_WIDTH-1:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_STO:  c.wr_ram = 1'b1;
            OPC_LD:   begin c.rd_ram = 1'b1; c.sel_a = SEL_A_RAM; c.wr_acc = 1'b1; end
            OPC_LDI:  begin c.sel_a = SEL_A_IMM; c.wr_acc = 1'b1; end
            OPC_ADD:  begin c.rd_ram = 1'b1; c.sel_a = SEL_A_ALU; c.op = 1'b1; c.wr_acc = 1'b1; end
            OPC_ADDI: begin c.sel_a = SEL_A_ALU; c.sel_b = 1'b1; c.op = 1'b1; c.wr_acc = 1'b1; end
            OPC_SUB:  begin c.rd_ram = 1'b1; c.sel_a = SEL_A_ALU; c.wr_acc = 1'b1; end
            OPC_SUBI: begin c.sel_a = SEL_A_ALU; c.sel_b = 1'b1; c.wr_acc = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] ir;
    ctrl_t                  ctrl;

    logic [OPCODE_WIDTH-1:0] ir_opc;
    logic [OPCODE_WIDTH-1:0] instr_opc;

    assign ir_opc    = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign instr_opc = bus.instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    // Strobes are decoded from the ROM word on the DECODE edge so they are
    // registered yet present for exactly the EXEC cycle, and cleared after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc_q   <= '0;
            ir     <= '0;
            ctrl   <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH;
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir    <= bus.instr;
                    ctrl  <= decode(instr_opc);
                    state <= EXEC;
                end
                EXEC: begin
                    ctrl <= '0;
                    if (ir_opc == OPC_HLT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc_q  <= pc_q + PC_WIDTH'(1);
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= IDLE;
                    ctrl   <= '0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc      = pc_q;
    assign bus.operand = ir[PC_WIDTH-1:0];
    assign bus.sel_a   = ctrl.sel_a;
    assign bus.sel_b   = ctrl.sel_b;
    assign bus.op      = ctrl.op;
    assign bus.wr_acc  = ctrl.wr_acc;
    assign bus.rd_ram  = ctrl.rd_ram;
    assign bus.wr_ram  = ctrl.wr_ram;

`ifdef BIP_CYCLE_COUNT_EN
    logic [CYCLE_WIDTH-1:0] cycle_cnt;

    // Counts every cycle spent sequencing, including the EXEC of HLT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (state == FETCH || state == DECODE || state == EXEC) begin
            cycle_cnt <= cycle_cnt + CYCLE_WIDTH'(1);
        end
    end

    assign cycles = cycle_cnt;
`else
    assign cycles = '0;
`endif

endmodule
